mux_reg_n: RTL and testbench
============================

# mux_reg_n

Parametrised, registered N:1 datapath selector, the next generation of the datapath's combinational 4:1 multiplexers. It chooses one of N WIDTH-bit sources, either by an explicit select (direct mode) or by round-robin among requesting sources (arbitration mode), and captures the result in a single output register with a valid/ready handshake. It sits between multiple producers, such as ALU, memory data register and shifter, and a single consumer, such as the register-file write port. It gives the datapath a stall-safe, parametrised replacement for hard-wired 4:1 muxes.

## Interface
- WIDTH, 32, data width per source
- N, 4, number of sources (2..16); SELW = $clog2(N) is a derived localparam
- RESET_VAL, 0, reset value of out_data
- clk  in  1  rising-edge clock (single clock domain)
- reset_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = direct select, 1 = round-robin arbitration
- sel  in  SELW  source index, used in direct mode only
- in_data  in  N*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-source valid
- in_ready  out  N  per-source ready, at most one bit set
- out_data  out  WIDTH  registered selected data
- out_sel  out  SELW  index of the source held in out_data
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data
- err_sel  out  1  registered one-cycle flag for an out-of-range sel in direct mode

## Operation
- Stage free: `free = ~out_valid | out_ready`.
- Direct mode:
  - When sel < N, the candidate is sel.
  - When sel >= N (only possible for non-power-of-two N), there is no candidate, no transfer, and err_sel = 1 on the next cycle.
- Round-robin mode:
  - The candidate is the first i with in_valid[i] = 1, searching cyclically from ptr+1.
  - If no source is valid, there is no candidate.
- Ready: `in_ready[c] = free` for the candidate c, and 0 for all other sources. in_ready does not depend on in_valid in direct mode.
- Transfer on source c: in_valid[c] & in_ready[c]. At the next edge, out_data ← source c, out_sel ← c, out_valid ← 1.
- ptr update:
  - ptr ← c only on a transfer in round-robin mode.
  - Direct-mode transfers leave ptr unchanged.
- Consume: out_valid & out_ready with no new transfer gives out_valid ← 0.
- Simultaneous consume and transfer: out_valid stays 1 and the new word is loaded, giving full throughput with no bubble.
- Holding: while out_valid = 0, out_data and out_sel hold their last values.
- Mode change: takes effect in the same cycle for candidate selection. ptr is retained across the change.
- err_sel: combinationally `(mode == 0) & (sel >= N)`, registered, with no stickiness. It is constant 0 when N is a power of two.

## Timing
- Latency: 1 cycle from a transfer to out_valid / out_data.
- Throughput: 1 word per cycle while out_ready = 1.
- in_ready is combinational from mode, sel, in_valid, out_valid and out_ready. out_data, out_sel, out_valid and err_sel come from registers only.
- Reset values, applied asynchronously on reset_n = 0 and independent of clk:
  - out_valid = 0, out_data = RESET_VAL, out_sel = 0, err_sel = 0
  - ptr = N-1, so the first round-robin grant searches from source 0
- Reset mid-operation: a held word is dropped with no handshake. in_ready follows `free` = 1 during reset but no capture occurs.
- Release: the first capture is possible at the first rising edge after reset_n rises.
- Producers must hold in_data and in_valid stable until in_ready is seen.

## Structure
- Shared package mux_pkg:
  - MODE_DIRECT = 1'b0, MODE_RR = 1'b1
  - a function for flattened-bus slicing
- Sub-module rr_arbiter (N, SELW):
  - inputs: req[N], ptr
  - outputs: grant index and any_grant (combinational rotate-and-priority-encode)
  - mux_reg_n instantiates it and owns the ptr register.
- The top level contains the output register, the handshake logic and err_sel.

## Test plan
- Reset: hold reset_n = 0 with random inputs. Require out_valid = 0, out_data = 0, out_sel = 0 and err_sel = 0. Assert reset_n = 0 asynchronously mid-cycle while out_valid = 1; out_valid must drop before the next edge.
- Direct select (N = 4):
  - Drive mode = 0, sel = 2, in_valid = 4'b0100, source 2 = 0xCAFEBABE, out_ready = 1.
  - Require in_ready = 4'b0100, then next cycle out_valid = 1, out_data = 0xCAFEBABE, out_sel = 2.
- Backpressure:
  - Set out_ready = 0 with out_valid = 1 for 5 cycles and change source 2 to 0x12345678.
  - Require out_data stable at 0xCAFEBABE and in_ready = 0 throughout.
  - Raise out_ready; require 0x12345678 on the next cycle with no bubble.
- Round-robin:
  - Drive mode = 1 and hold in_valid = 4'b1111, out_ready = 1.
  - Require out_sel sequence 0, 1, 2, 3, 0.
  - Then drive in_valid = 4'b1010 from ptr = 0; require grants 1, 3, 1.
- Out-of-range select (N = 3):
  - Drive mode = 0, sel = 3, in_valid = 3'b111.
  - Require in_ready = 0, no transfer, err_sel = 1 one cycle later, and err_sel = 0 one cycle after sel returns to 1.
- Mode switch:
  - Make grants 0 and 1 in round-robin, then make one direct transfer with sel = 3.
  - Return to round-robin; the next grant must be 2, showing ptr is retained.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 datapath selector.
//   MODE_DIRECT / MODE_RR : encodings of the mode input
//   slice_lo()            : low bit of source idx inside a flattened bus
package mux_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   // Source idx occupies bits [slice_lo(idx, width) +: width] of a flattened bus.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational rotate-and-priority-encode.
//   req       in  N     request vector
//   ptr       in  SELW  index of the last granted source
//   grant     out SELW  first requesting index searching cyclically from ptr+1
//   any_grant out 1     some request is present
module rr_arbiter #(
   parameter int unsigned N    = 4,
   parameter int unsigned SELW = 2
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] grant,
   output logic            any_grant
);

   logic [SELW-1:0] idx;

   // Lowest cyclic distance from ptr wins; later hits are ignored once found.
   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      idx       = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = SELW'((32'(ptr) + k) % N);
         if (!any_grant && req[idx]) begin
            grant     = idx;
            any_grant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_reg_n.sv
// Registered N:1 datapath selector with valid/ready handshake.
// Picks one of N WIDTH-bit sources by explicit sel (direct mode) or by
// round-robin among valid sources, and holds it in one output register.
//   clk, reset_n        clock, async active-low reset
//   mode                0 = direct select, 1 = round-robin
//   sel                 source index for direct mode
//   in_data/in_valid    flattened sources and their valids
//   in_ready            per-source ready (at most one set, combinational)
//   out_data/out_sel    registered word and its source index
//   out_valid/out_ready output handshake
//   err_sel             registered flag for an out-of-range sel in direct mode
module mux_reg_n
   import mux_pkg::*;
#(
   parameter  int unsigned      WIDTH     = 32,
   parameter  int unsigned      N         = 4,
   parameter  logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned      SELW      = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 err_sel
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  grant_c;
   logic             any_grant_c;
   logic [SELW-1:0]  cand_c;
   logic             has_cand_c;
   logic             free_c;
   logic             xfer_c;
   logic             err_c;
   logic [WIDTH-1:0] data_c;

   rr_arbiter #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .grant     (grant_c),
      .any_grant (any_grant_c)
   );

   // Candidate selection, ready generation and transfer detection.
   always_comb begin
      free_c     = ~out_valid | out_ready;
      err_c      = (mode == MODE_DIRECT) && (32'(sel) >= N);
      has_cand_c = 1'b0;
      cand_c     = '0;
      in_ready   = '0;
      data_c     = '0;
      xfer_c     = 1'b0;

      if (mode == MODE_DIRECT) begin
         has_cand_c = 32'(sel) < N;
         cand_c     = has_cand_c ? sel : '0;
      end else begin
         has_cand_c = any_grant_c;
         cand_c     = grant_c;
      end

      for (int unsigned i = 0; i < N; i++) begin
         if (cand_c == SELW'(i)) begin
            in_ready[i] = has_cand_c & free_c;
            data_c      = in_data[slice_lo(i, WIDTH) +: WIDTH];
         end
      end

      xfer_c = |(in_ready & in_valid);
   end

   // Output register, round-robin pointer and error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= RESET_VAL;
         out_sel   <= '0;
         err_sel   <= 1'b0;
         ptr       <= SELW'(N - 1);
      end else begin
         err_sel <= err_c;
         if (xfer_c) begin
            out_data  <= data_c;
            out_sel   <= cand_c;
            out_valid <= 1'b1;
            if (mode == MODE_RR) begin
               ptr <= cand_c;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_reg_n.sv
// Self-checking bench for mux_reg_n: one N=4 and one N=3 instance, checked
// every cycle against a behavioural model plus directed scenario checks.
module tb_mux_reg_n;

   typedef struct {
      int          ptr;
      bit          ov;
      logic [31:0] od;
      int          os;
      bit          err;
   } mst_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // N = 4 instance
   logic         mode4;
   logic [1:0]   sel4;
   logic [31:0]  d4 [4];
   logic [127:0] in_data4;
   logic [3:0]   in_valid4, in_ready4;
   logic [31:0]  out_data4;
   logic [1:0]   out_sel4;
   logic         out_valid4, out_ready4, err4;
   assign in_data4 = {d4[3], d4[2], d4[1], d4[0]};

   // N = 3 instance
   logic         mode3;
   logic [1:0]   sel3;
   logic [31:0]  d3 [4];
   logic [95:0]  in_data3;
   logic [2:0]   in_valid3, in_ready3;
   logic [31:0]  out_data3;
   logic [1:0]   out_sel3;
   logic         out_valid3, out_ready3, err3;
   assign in_data3 = {d3[2], d3[1], d3[0]};

   mux_reg_n #(.WIDTH(32), .N(4), .RESET_VAL(32'h0)) u4 (
      .clk(clk), .reset_n(reset_n), .mode(mode4), .sel(sel4),
      .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
      .out_data(out_data4), .out_sel(out_sel4), .out_valid(out_valid4),
      .out_ready(out_ready4), .err_sel(err4));

   mux_reg_n #(.WIDTH(32), .N(3), .RESET_VAL(32'h0)) u3 (
      .clk(clk), .reset_n(reset_n), .mode(mode3), .sel(sel3),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
      .out_ready(out_ready3), .err_sel(err3));

   int   checks = 0;
   int   errors = 0;
   mst_t m4, m3;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic mst_t rst_state(input int n);
      mst_t s;
      s.ptr = n - 1; s.ov = 1'b0; s.od = 32'h0; s.os = 0; s.err = 1'b0;
      return s;
   endfunction

   // Candidate source, or -1 when there is none.
   function automatic int cand_of(input int n, input bit mode, input int sel,
                                  input int valid, input int ptr);
      if (!mode) return (sel < n) ? sel : -1;
      for (int k = 1; k <= n; k++) begin
         int i;
         i = (ptr + k) % n;
         if (valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic int exp_ready(input mst_t s, input int n, input bit mode, input int sel,
                                    input int valid, input bit ordy);
      int c;
      bit free;
      c    = cand_of(n, mode, sel, valid, s.ptr);
      free = !s.ov || ordy;
      return (c >= 0 && free) ? (1 << c) : 0;
   endfunction

   function automatic mst_t step(input mst_t s, input int n, input bit mode, input int sel,
                                 input int valid, input logic [31:0] d [4], input bit ordy);
      mst_t r;
      int   c;
      bit   free;
      r    = s;
      c    = cand_of(n, mode, sel, valid, s.ptr);
      free = !s.ov || ordy;
      if (c >= 0 && free && valid[c]) begin
         r.od = d[c];
         r.os = c;
         r.ov = 1'b1;
         if (mode) r.ptr = c;
      end else if (s.ov && ordy) begin
         r.ov = 1'b0;
      end
      r.err = !mode && (sel >= n);
      return r;
   endfunction

   // One clock: check in_ready, advance model at the edge, check registers.
   task automatic cycle();
      #1;
      check("in_ready4", 128'(in_ready4),
            128'(exp_ready(m4, 4, mode4, int'(sel4), int'(in_valid4), out_ready4)));
      check("in_ready3", 128'(in_ready3),
            128'(exp_ready(m3, 3, mode3, int'(sel3), int'(in_valid3), out_ready3)));
      @(posedge clk);
      if (reset_n) begin
         m4 = step(m4, 4, mode4, int'(sel4), int'(in_valid4), d4, out_ready4);
         m3 = step(m3, 3, mode3, int'(sel3), int'(in_valid3), d3, out_ready3);
      end else begin
         m4 = rst_state(4);
         m3 = rst_state(3);
      end
      @(negedge clk);
      check("out_valid4", 128'(out_valid4), 128'(m4.ov));
      check("out_data4",  128'(out_data4),  128'(m4.od));
      check("out_sel4",   128'(out_sel4),   128'(m4.os));
      check("err_sel4",   128'(err4),       128'(m4.err));
      check("out_valid3", 128'(out_valid3), 128'(m3.ov));
      check("out_data3",  128'(out_data3),  128'(m3.od));
      check("out_sel3",   128'(out_sel3),   128'(m3.os));
      check("err_sel3",   128'(err3),       128'(m3.err));
   endtask

   task automatic rand_inputs();
      mode4 = 1'($urandom); sel4 = 2'($urandom); in_valid4 = 4'($urandom);
      out_ready4 = ($urandom_range(0, 9) < 7);
      mode3 = 1'($urandom); sel3 = 2'($urandom); in_valid3 = 3'($urandom);
      out_ready3 = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) begin
         d4[i] = $urandom;
         d3[i] = $urandom;
      end
   endtask

   task automatic idle3();
      mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;
   endtask

   task automatic idle4();
      mode4 = 1'b0; sel4 = 2'd0; in_valid4 = 4'b0000; out_ready4 = 1'b1;
   endtask

   int rr_a [5] = '{0, 1, 2, 3, 0};
   int rr_b [3] = '{1, 3, 1};

   initial begin
      reset_n = 1'b0;
      rand_inputs();
      m4 = rst_state(4);
      m3 = rst_state(3);
      @(negedge clk);

      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         cycle();
      end
      check("rst_valid4", 128'(out_valid4), 128'(0));
      check("rst_data4",  128'(out_data4),  128'(0));
      check("rst_sel4",   128'(out_sel4),   128'(0));
      check("rst_err3",   128'(err3),       128'(0));

      reset_n = 1'b1;
      idle4();
      idle3();
      cycle();

      // Direct select.
      mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b0100; d4[2] = 32'hCAFEBABE; out_ready4 = 1'b1;
      #1 check("direct_ready", 128'(in_ready4), 128'(4'b0100));
      cycle();
      check("direct_valid", 128'(out_valid4), 128'(1));
      check("direct_data",  128'(out_data4),  128'(32'hCAFEBABE));
      check("direct_sel",   128'(out_sel4),   128'(2));

      // Backpressure.
      out_ready4 = 1'b0;
      d4[2] = 32'h12345678;
      for (int i = 0; i < 5; i++) begin
         #1 check("bp_ready", 128'(in_ready4), 128'(0));
         cycle();
         check("bp_data", 128'(out_data4), 128'(32'hCAFEBABE));
      end
      out_ready4 = 1'b1;
      cycle();
      check("bp_release_valid", 128'(out_valid4), 128'(1));
      check("bp_release_data",  128'(out_data4),  128'(32'h12345678));

      // Round-robin.
      mode4 = 1'b1; in_valid4 = 4'b1111;
      for (int i = 0; i < 4; i++) d4[i] = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("rr_all", 128'(out_sel4), 128'(rr_a[i]));
      end
      in_valid4 = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("rr_sparse", 128'(out_sel4), 128'(rr_b[i]));
      end

      // Mode switch keeps ptr.
      in_valid4 = 4'b0001;
      cycle();
      check("ms_grant0", 128'(out_sel4), 128'(0));
      in_valid4 = 4'b0010;
      cycle();
      check("ms_grant1", 128'(out_sel4), 128'(1));
      mode4 = 1'b0; sel4 = 2'd3; in_valid4 = 4'b1000;
      cycle();
      check("ms_direct", 128'(out_sel4), 128'(3));
      mode4 = 1'b1; in_valid4 = 4'b1111;
      cycle();
      check("ms_rr_resume", 128'(out_sel4), 128'(2));

      // Out-of-range select on N = 3.
      idle4();
      cycle();
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
      for (int i = 0; i < 3; i++) d3[i] = 32'hB000_0000 + 32'(i);
      #1 check("oor_ready", 128'(in_ready3), 128'(0));
      cycle();
      check("oor_err",   128'(err3),       128'(1));
      check("oor_valid", 128'(out_valid3), 128'(0));
      sel3 = 2'd1;
      cycle();
      check("oor_err_clear", 128'(err3),      128'(0));
      check("oor_recover",   128'(out_data3), 128'(32'hB000_0001));

      // Asynchronous reset mid-cycle while a word is held.
      idle3();
      mode4 = 1'b0; sel4 = 2'd0; in_valid4 = 4'b0001; d4[0] = 32'h5555AAAA; out_ready4 = 1'b0;
      cycle();
      check("pre_rst_valid", 128'(out_valid4), 128'(1));
      #7 reset_n = 1'b0;
      #1;
      check("async_rst_valid", 128'(out_valid4), 128'(0));
      check("async_rst_data",  128'(out_data4),  128'(0));
      m4 = rst_state(4);
      m3 = rst_state(3);
      @(negedge clk);
      reset_n = 1'b1;
      idle4();
      cycle();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
